// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the 5-stage RV32I pipeline.
//
// Fetches one 32-bit instruction as four byte reads over the shared 8-bit
// memory port and assembles it little-endian. The assembled instruction is
// presented on pc/is with ok=1 and held until downstream accepts it
// (stall=0). A redirect (jmp) from decode/execute abandons any fetch in
// progress and restarts from the new, word-aligned target.
//
// Ports:
//   clk       in   1   clock, all state updates on rising edge
//   rst       in   1   synchronous active-high reset
//   stall     in   1   downstream cannot accept; hold current output
//   jmp       in   1   redirect request, valid this cycle
//   jmp_pc    in  32   redirect target (bits [1:0] forced to 0)
//   mem_busy  in   1   memory port owned by MEM stage; do not issue
//   mem_din   in   8   read data, valid the cycle after its mem_rd
//   mem_rd    out  1   byte read request (combinational)
//   mem_a     out 32   byte address (combinational)
//   pc        out 32   address of presented instruction (registered)
//   is        out 32   presented instruction, 0 when ok=0 (bubble)
//   ok        out  1   pc/is valid (registered)
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_pc,
    input  logic        mem_busy,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic [31:0] mem_a,
    output logic [31:0] pc,
    output logic [31:0] is,
    output logic        ok
);

    // Number of byte reads issued / bytes captured for the current word.
    logic [2:0] issue_cnt;
    logic [2:0] recv_cnt;

    // High when a read was issued last cycle, i.e. mem_din carries a byte now.
    logic       inflight;

    // Lower three bytes of the word; byte 3 goes straight from mem_din into is.
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;

    // A read goes out only while the port is ours, nothing is being
    // presented, and fewer than four bytes of the word have been requested.
    // The address is driven to zero when idle so the shared bus stays quiet.
    always_comb begin
        mem_rd = !rst && !jmp && !mem_busy && !ok && (issue_cnt < 3'd4);
        mem_a  = mem_rd ? (pc + {29'd0, issue_cnt}) : 32'd0;
    end

    // Sequential state. Reset beats redirect, redirect beats everything else.
    // Capture does not look at mem_busy: a byte requested last cycle always
    // arrives and must be taken, otherwise it would be lost. On the fourth
    // byte the word is assembled directly from mem_din to save a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            inflight  <= 1'b0;
            ok        <= 1'b0;
            is        <= 32'd0;
            b0        <= 8'd0;
            b1        <= 8'd0;
            b2        <= 8'd0;
        end else if (jmp) begin
            pc        <= {jmp_pc[31:2], 2'b00};
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            inflight  <= 1'b0;
            ok        <= 1'b0;
            is        <= 32'd0;
        end else begin
            inflight <= mem_rd;

            if (mem_rd) begin
                issue_cnt <= issue_cnt + 3'd1;
            end

            if (inflight) begin
                case (recv_cnt)
                    3'd0:    b0 <= mem_din;
                    3'd1:    b1 <= mem_din;
                    3'd2:    b2 <= mem_din;
                    default: ;
                endcase

                if (recv_cnt == 3'd3) begin
                    is        <= {mem_din, b2, b1, b0};
                    ok        <= 1'b1;
                    issue_cnt <= 3'd0;
                    recv_cnt  <= 3'd0;
                end else begin
                    recv_cnt <= recv_cnt + 3'd1;
                end
            end

            // Hand-off: downstream took the instruction, move to the next word.
            if (ok && !stall) begin
                ok <= 1'b0;
                is <= 32'd0;
                pc <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
//
// A byte-addressed memory is modelled as a pure function of the address.
// A reference model tracks the fetch stage in terms of "how many bytes have
// been requested / have come back for the word at model pc" and, whenever a
// word completes, pushes the expected {pc, instruction} into a scoreboard
// queue. A separate monitor pops and compares each time the DUT raises ok.
// Directed sequences cover the scenarios of interest, then a random phase
// mixes stall, mem_busy, jmp and rst.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jmp;
    logic [31:0] jmp_pc;
    logic        mem_busy;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic [31:0] mem_a;
    logic [31:0] pc;
    logic [31:0] is;
    logic        ok;

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .jmp      (jmp),
        .jmp_pc   (jmp_pc),
        .mem_busy (mem_busy),
        .mem_din  (mem_din),
        .mem_rd   (mem_rd),
        .mem_a    (mem_a),
        .pc       (pc),
        .is       (is),
        .ok       (ok)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc;
    logic        m_ok;
    int          m_iss;
    int          m_recv;
    logic        m_infl;
    logic        m_known = 1'b0;

    // Values observed in the most recent cycle (sampled mid-cycle)
    logic        obs_rd;
    logic [31:0] obs_a;
    logic        obs_ok;
    logic [31:0] obs_pc;
    logic [31:0] obs_is;

    // Memory-side bookkeeping for returning read data
    logic        last_rd = 1'b0;
    logic [31:0] last_a  = 32'd0;

    // Memory contents: first word is addi a0,x0,1 (0x00100513), rest hashed.
    function automatic logic [7:0] memb(input logic [31:0] a);
        logic [7:0] h;
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: begin
                h = a[7:0] * 8'd37;
                h = h ^ a[15:8] ^ a[23:16] ^ (a[31:24] + 8'h5A);
                return h;
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {memb(a + 32'd3), memb(a + 32'd2), memb(a + 32'd1), memb(a)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare the
    // DUT against the model mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input logic r, input logic j, input logic [31:0] jp,
                                 input logic st, input logic bz);
        logic        e_rd;
        logic [31:0] e_a;
        logic        was_ok;
        @(negedge clk);
        mem_din  = last_rd ? memb(last_a) : 8'($urandom);
        rst      = r;
        jmp      = j;
        jmp_pc   = jp;
        stall    = st;
        mem_busy = bz;
        #1;
        obs_rd = mem_rd;
        obs_a  = mem_a;
        obs_ok = ok;
        obs_pc = pc;
        obs_is = is;

        if (r) begin
            e_rd = 1'b0;
        end else begin
            e_rd = !j && !bz && !m_ok && (m_iss < 4);
        end
        e_a = e_rd ? (m_pc + 32'(m_iss)) : 32'd0;
        if (m_known || r) begin
            checkOutput("mem_rd", 32'(obs_rd), 32'(e_rd));
            checkOutput("mem_a", obs_a, e_a);
        end
        if (m_known) begin
            checkOutput("ok", 32'(obs_ok), 32'(m_ok));
            checkOutput("pc", obs_pc, m_pc);
            checkOutput("is", obs_is, m_ok ? word_at(m_pc) : 32'd0);
        end
        last_rd = obs_rd;
        last_a  = obs_a;

        @(posedge clk);
        was_ok = m_ok;
        if (r) begin
            m_known = 1'b1;
            m_pc    = 32'h0;
            m_ok    = 1'b0;
            m_iss   = 0;
            m_recv  = 0;
            m_infl  = 1'b0;
            sb.delete();
        end else if (j) begin
            m_pc   = {jp[31:2], 2'b00};
            m_ok   = 1'b0;
            m_iss  = 0;
            m_recv = 0;
            m_infl = 1'b0;
        end else if (m_known) begin
            if (m_infl) begin
                m_recv++;
                if (m_recv == 4) begin
                    m_ok   = 1'b1;
                    m_iss  = 0;
                    m_recv = 0;
                    sb.push_back('{pc: m_pc, ins: word_at(m_pc)});
                end
            end
            m_infl = e_rd;
            if (e_rd) m_iss++;
            if (was_ok && !st) begin
                m_ok = 1'b0;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Run stalled cycles until the DUT presents an instruction (bounded).
    task automatic waitOk(output int n);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            n++;
        end while (!obs_ok && n < 20);
        checkOutput("wait_ok", 32'(obs_ok), 32'd1);
    endtask

    // Scoreboard monitor: every rising ok must match the oldest expectation.
    logic ok_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (ok === 1'b1 && ok_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("[TB] FAIL sb_empty: got ok with pc %h, expected no instruction", pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_pc", pc, e.pc);
                checkOutput("sb_is", is, e.ins);
            end
        end
        ok_prev = ok;
    end

    initial begin
        int n;
        rst = 1'b1; jmp = 1'b0; jmp_pc = 32'd0; stall = 1'b0;
        mem_busy = 1'b0; mem_din = 8'd0;
        m_pc = 32'd0; m_ok = 1'b0; m_iss = 0; m_recv = 0; m_infl = 1'b0;

        // Reset
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("rst_rd", 32'(obs_rd), 32'd0);

        // First fetch: addresses 0..3, ok in cycle 5 with 0x00100513
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            checkOutput($sformatf("t1_a%0d", i), obs_a, 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("t1_c4_ok", 32'(obs_ok), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("t1_ok", 32'(obs_ok), 32'd1);
        checkOutput("t1_pc", obs_pc, 32'd0);
        checkOutput("t1_is", obs_is, 32'h00100513);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t1_c6_ok", 32'(obs_ok), 32'd0);
        checkOutput("t1_c6_is", obs_is, 32'd0);
        checkOutput("t1_c6_a", obs_a, 32'd4);

        // Stall holds the presented instruction
        waitOk(n);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            checkOutput("t2_hold_ok", 32'(obs_ok), 32'd1);
            checkOutput("t2_hold_pc", obs_pc, 32'd4);
            checkOutput("t2_hold_rd", 32'(obs_rd), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("t2_pc", obs_pc, 32'd8);
        checkOutput("t2_a", obs_a, 32'd8);

        // mem_busy in cycles 1-2: ok arrives in cycle 7
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("t3_busy_rd", 32'(obs_rd), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        waitOk(n);
        checkOutput("t3_latency", 32'(n), 32'd5);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Redirect mid-fetch
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("t4_a0", obs_a, 32'd12);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h00001003, 1'b0, 1'b0);
        checkOutput("t4_jmp_rd", 32'(obs_rd), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            checkOutput($sformatf("t4_a%0d", i), obs_a, 32'h1000 + 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t4_ok", 32'(obs_ok), 32'd1);
        checkOutput("t4_pc", obs_pc, 32'h1000);

        // jmp + stall while ok, then reset mid-fetch
        applyStimulus(1'b0, 1'b1, 32'h00002000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("t5_ok", 32'(obs_ok), 32'd0);
        checkOutput("t5_pc", obs_pc, 32'h2000);
        checkOutput("t5_a", obs_a, 32'h2000);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("t5_rst_rd", 32'(obs_rd), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("t5_rst_pc", obs_pc, 32'd0);
        checkOutput("t5_rst_a", obs_a, 32'd0);

        // Address wrap at the top of memory
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            checkOutput($sformatf("t6_a%0d", i), obs_a, 32'hFFFFFFFC + 32'(i));
        end
        waitOk(n);
        checkOutput("t6_pc", obs_pc, 32'hFFFFFFFC);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("t6_wrap_pc", obs_pc, 32'd0);
        checkOutput("t6_wrap_a", obs_a, 32'd0);

        // Random mix of stall, busy, redirect and occasional reset
        for (int i = 0; i < 600; i++) begin
            logic        r, j, st, bz;
            logic [31:0] jp;
            r  = ($urandom_range(0, 99) == 0);
            j  = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 2) == 0);
            bz = ($urandom_range(0, 3) == 0);
            jp = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            applyStimulus(r, j, jp, st, bz);
        end

        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
